// File: rtl/display_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: divides the clock into digit slots,
// walks a one-hot active-low anode and latches new values only at frame boundaries.
module display_scan_ctrl #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    output logic                  ready,
    output logic [3:0]            seg_code,
    output logic [DIGITS-1:0]     an
);

    localparam int unsigned IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNTW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [DIGITS-1:0][3:0] disp_q, disp_d;
    logic [DIGITS-1:0][3:0] shadow_q, shadow_d;
    logic                   disp_lz_q, disp_lz_d;
    logic                   shadow_lz_q, shadow_lz_d;
    logic                   pending_q, pending_d;

    logic                   tick;
    logic                   frame_end;
    logic [DIGITS:0]        zero_from;
    logic [DIGITS-1:0][3:0] eff;

    always_comb begin
        tick      = (cnt_q == CNTW'(DIV - 1));
        frame_end = tick && (idx_q == IDXW'(DIGITS - 1));

        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDXW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        disp_d      = disp_q;
        disp_lz_d   = disp_lz_q;
        shadow_d    = shadow_q;
        shadow_lz_d = shadow_lz_q;
        pending_d   = pending_q;

        // Apply uses the pre-edge pending flag, so a load landing on the boundary only stages.
        if (frame_end && pending_q) begin
            disp_d    = shadow_q;
            disp_lz_d = shadow_lz_q;
            pending_d = 1'b0;
        end else if (load && !pending_q) begin
            shadow_d    = value;
            shadow_lz_d = blank_lz;
            pending_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            disp_q      <= '1;
            disp_lz_q   <= 1'b0;
            shadow_q    <= '0;
            shadow_lz_q <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            disp_lz_q   <= disp_lz_d;
            shadow_q    <= shadow_d;
            shadow_lz_q <= shadow_lz_d;
            pending_q   <= pending_d;
        end
    end

    // zero_from[i]: digits i..DIGITS-1 are all zero (top sentinel is vacuously true).
    always_comb begin
        zero_from         = '0;
        zero_from[DIGITS] = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            zero_from[DIGITS-1-k] = (disp_q[DIGITS-1-k] == 4'h0) && zero_from[DIGITS-k];
        end
        eff = disp_q;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            if (disp_lz_q && zero_from[i]) begin
                eff[i] = 4'hF;
            end
        end
    end

    always_comb begin
        ready    = ~pending_q;
        seg_code = eff[idx_q];
        an       = ~(DIGITS'(1) << idx_q);
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed scenarios plus random traffic
// compared every cycle against a cycle-count based reference model.
module tb_display_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic        blank_lz = 1'b0;
    logic        ready;
    logic [3:0]  seg_code;
    logic [3:0]  an;

    logic        rst2 = 1'b1;
    logic        load2 = 1'b0;
    logic [7:0]  value2 = '0;
    logic        blank2 = 1'b0;
    logic        ready2;
    logic [3:0]  seg2;
    logic [1:0]  an2;

    int errors = 0;
    int checks = 0;

    // Reference model: cycles since reset determine the slot; display state kept as arrays.
    int         cyc = 0;
    logic [3:0] m_disp[DIGITS];
    logic [3:0] m_shadow[DIGITS];
    logic       m_lz = 1'b0;
    logic       m_shadow_lz = 1'b0;
    logic       m_pending = 1'b0;

    display_scan_ctrl #(.DIGITS(4), .DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .blank_lz(blank_lz),
        .ready(ready), .seg_code(seg_code), .an(an)
    );

    display_scan_ctrl #(.DIGITS(2), .DIV(2)) dut2 (
        .clk(clk), .rst(rst2), .load(load2), .value(value2), .blank_lz(blank2),
        .ready(ready2), .seg_code(seg2), .an(an2)
    );

    always #5 clk = ~clk;

    function automatic int cur_idx();
        return (cyc / DIV) % DIGITS;
    endfunction

    function automatic logic [3:0] eff_digit(int i);
        logic allz;
        allz = 1'b1;
        for (int j = i; j < DIGITS; j++) if (m_disp[j] != 4'h0) allz = 1'b0;
        if (m_lz && i != 0 && allz) return 4'hF;
        return m_disp[i];
    endfunction

    function automatic logic [8:0] exp_vec();
        logic [3:0] a;
        a = ~(4'b0001 << cur_idx());
        return {~m_pending, a, eff_digit(cur_idx())};
    endfunction

    task automatic model_update();
        if (rst) begin
            cyc = 0;
            for (int i = 0; i < DIGITS; i++) begin
                m_disp[i]   = 4'hF;
                m_shadow[i] = 4'h0;
            end
            m_lz = 1'b0; m_shadow_lz = 1'b0; m_pending = 1'b0;
        end else begin
            if ((cyc % FRAME) == FRAME - 1 && m_pending) begin
                for (int i = 0; i < DIGITS; i++) m_disp[i] = m_shadow[i];
                m_lz = m_shadow_lz;
                m_pending = 1'b0;
            end else if (load && !m_pending) begin
                for (int i = 0; i < DIGITS; i++) m_shadow[i] = value[4*i +: 4];
                m_shadow_lz = blank_lz;
                m_pending = 1'b1;
            end
            cyc++;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic align(int phase);
        for (int k = 0; k < 2 * FRAME && (cyc % FRAME) != phase; k++) advance();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        advance();
        advance();
        rst = 1'b0;
        checks++;
        if ({ready, an, seg_code} !== 9'b1_1110_1111) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", {ready, an, seg_code}, 9'b1_1110_1111);
        end
        for (int k = 0; k <= FRAME; k++) begin
            logic [3:0] ea;
            ea = ~(4'b0001 << ((k / DIV) % DIGITS));
            checks++;
            if (an !== ea || seg_code !== 4'hF || {ready, an, seg_code} !== exp_vec()) begin
                errors++;
                $display("FAIL reset_walk k=%0d got an=%b seg=%h exp an=%b seg=F", k, an, seg_code, ea);
            end
            if (k < FRAME) advance();
        end
    endtask

    task automatic test_basic_load();
        logic [15:0] v;
        v = 16'h1234;
        align(DIV);
        value = v; blank_lz = 1'b0; load = 1'b1;
        advance();
        load = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy got=%b exp=0", ready);
        end
        for (int k = 0; k < 2 * FRAME && m_pending; k++) begin
            checks++;
            if ({ready, an, seg_code} !== exp_vec()) begin
                errors++;
                $display("FAIL basic_wait got=%h exp=%h", {ready, an, seg_code}, exp_vec());
            end
            advance();
        end
        for (int k = 0; k < FRAME; k++) begin
            logic [3:0] ea;
            ea = ~(4'b0001 << (k / DIV));
            checks++;
            if (ready !== 1'b1 || an !== ea || seg_code !== v[4*(k/DIV) +: 4]) begin
                errors++;
                $display("FAIL basic_frame k=%0d got rdy=%b an=%b seg=%h exp rdy=1 an=%b seg=%h",
                         k, ready, an, seg_code, ea, v[4*(k/DIV) +: 4]);
            end
            advance();
        end
    endtask

    task automatic test_blanking();
        logic [15:0] vals[2];
        logic [15:0] shown[2];
        vals[0] = 16'h0050; shown[0] = 16'hFF50;
        vals[1] = 16'h0000; shown[1] = 16'hFFF0;
        for (int t = 0; t < 2; t++) begin
            align(0);
            value = vals[t]; blank_lz = 1'b1; load = 1'b1;
            advance();
            load = 1'b0; blank_lz = 1'b0;
            for (int k = 0; k < 2 * FRAME && m_pending; k++) advance();
            for (int k = 0; k < FRAME; k++) begin
                checks++;
                if (seg_code !== shown[t][4*(k/DIV) +: 4] || {ready, an, seg_code} !== exp_vec()) begin
                    errors++;
                    $display("FAIL blank_frame t=%0d k=%0d got=%h exp=%h",
                             t, k, seg_code, shown[t][4*(k/DIV) +: 4]);
                end
                advance();
            end
        end
    endtask

    task automatic test_busy_ignore();
        int rises;
        logic prev;
        align(0);
        value = 16'h1111; load = 1'b1;
        advance();
        load = 1'b0;
        advance();
        value = 16'h2222; load = 1'b1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready got=%b exp=0", ready);
        end
        advance();
        load = 1'b0;
        rises = 0;
        prev = ready;
        for (int k = 0; k < 3 * FRAME; k++) begin
            checks++;
            if ({ready, an, seg_code} !== exp_vec() || seg_code === 4'h2) begin
                errors++;
                $display("FAIL busy_scan k=%0d got=%h exp=%h", k, {ready, an, seg_code}, exp_vec());
            end
            if (ready && !prev) rises++;
            prev = ready;
            advance();
        end
        checks++;
        if (rises !== 1) begin
            errors++;
            $display("FAIL busy_rises got=%0d exp=1", rises);
        end
    endtask

    task automatic test_boundary_collision();
        logic [15:0] v;
        v = 16'h9876;
        align(FRAME - 1);
        value = v; load = 1'b1;
        advance();
        load = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (ready !== 1'b0 || seg_code !== 4'h1) begin
                errors++;
                $display("FAIL collide_old k=%0d got rdy=%b seg=%h exp rdy=0 seg=1", k, ready, seg_code);
            end
            advance();
        end
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (seg_code !== v[4*(k/DIV) +: 4] || {ready, an, seg_code} !== exp_vec()) begin
                errors++;
                $display("FAIL collide_new k=%0d got=%h exp=%h", k, seg_code, v[4*(k/DIV) +: 4]);
            end
            advance();
        end
    endtask

    task automatic test_reset_pending();
        align(2);
        value = 16'h4321; load = 1'b1;
        advance();
        load = 1'b0;
        advance();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        checks++;
        if ({ready, an, seg_code} !== 9'b1_1110_1111) begin
            errors++;
            $display("FAIL rstpend_state got=%b exp=%b", {ready, an, seg_code}, 9'b1_1110_1111);
        end
        for (int k = 0; k < 2 * FRAME; k++) begin
            checks++;
            if (seg_code !== 4'hF || ready !== 1'b1 || {ready, an, seg_code} !== exp_vec()) begin
                errors++;
                $display("FAIL rstpend_scan k=%0d got rdy=%b seg=%h exp rdy=1 seg=F", k, ready, seg_code);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            load = ($urandom_range(0, 5) == 0);
            blank_lz = $urandom_range(0, 1);
            rst = ($urandom_range(0, 150) == 0);
            for (int d = 0; d < DIGITS; d++) begin
                case ($urandom_range(0, 9))
                    0:       value[4*d +: 4] = 4'($urandom_range(10, 15));
                    1, 2, 3: value[4*d +: 4] = 4'h0;
                    default: value[4*d +: 4] = 4'($urandom_range(0, 9));
                endcase
            end
            advance();
            checks++;
            if ({ready, an, seg_code} !== exp_vec()) begin
                errors++;
                $display("FAIL random k=%0d got=%h exp=%h", k, {ready, an, seg_code}, exp_vec());
            end
        end
        rst = 1'b0; load = 1'b0;
    endtask

    task automatic test_wrap2();
        rst2 = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst2 = 1'b0;
        for (int n = 0; n < 8; n++) begin
            logic [1:0] ea;
            ea = (((n / 2) % 2) == 0) ? 2'b10 : 2'b01;
            checks++;
            if (an2 !== ea || seg2 !== 4'hF || ready2 !== 1'b1) begin
                errors++;
                $display("FAIL wrap2_walk n=%0d got an=%b seg=%h exp an=%b seg=F", n, an2, seg2, ea);
            end
            @(negedge clk);
        end
        value2 = 8'h30; blank2 = 1'b0; load2 = 1'b1;
        @(negedge clk);
        load2 = 1'b0;
        checks++;
        if (ready2 !== 1'b0) begin
            errors++;
            $display("FAIL wrap2_busy got=%b exp=0", ready2);
        end
        repeat (3) @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            logic [3:0] es;
            es = (n < 2) ? 4'h0 : 4'h3;
            checks++;
            if (ready2 !== 1'b1 || seg2 !== es) begin
                errors++;
                $display("FAIL wrap2_show n=%0d got rdy=%b seg=%h exp rdy=1 seg=%h", n, ready2, seg2, es);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_load();
        test_blanking();
        test_busy_ignore();
        test_boundary_collision();
        test_reset_pending();
        test_random();
        test_wrap2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
